// File: rtl/clkdiv_tick_monitor.sv
// Receive-side monitor for the board's slow toggle clock: synchronizes it, emits
// single-cycle edge strobes, measures the half-period and flags range and loss errors.
module clkdiv_tick_monitor #(
  parameter int              CW          = 25,
  parameter logic [CW-1:0]   EXP_HALF    = 25'd10000001,
  parameter logic [CW-1:0]   TOL         = 25'd1000,
  parameter logic [CW-1:0]   TIMEOUT_CYC = 25'd15000000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLKIN,
  output logic          LEVEL,
  output logic          TICK,
  output logic          RISE,
  output logic [CW-1:0] HALF_PERIOD,
  output logic          VALID,
  output logic          RANGE_ERR,
  output logic          TIMEOUT
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, LOST} state_t;

  localparam logic [CW-1:0] CNT_MAX      = '1;
  localparam logic [CW-1:0] TIMEOUT_LAST = TIMEOUT_CYC - CW'(1);
  // One extra bit so the upper bound cannot wrap; the lower bound floors at zero.
  localparam logic [CW:0]   RANGE_HI     = {1'b0, EXP_HALF} + {1'b0, TOL};
  localparam logic [CW:0]   RANGE_LO     = (EXP_HALF >= TOL) ? {1'b0, EXP_HALF - TOL} : '0;

  logic          sync1_q, sync2_q, prev_q;
  logic          level_q, tick_q, rise_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] half_q;
  logic          valid_q, range_err_q, timeout_q;
  state_t        state_q;

  logic          edge_det, rise_det, range_bad, timeout_hit;
  logic [CW-1:0] captured;

  always_comb begin
    edge_det    = sync2_q ^ prev_q;
    rise_det    = sync2_q & ~prev_q;
    captured    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
    range_bad   = ({1'b0, captured} > RANGE_HI) || ({1'b0, captured} < RANGE_LO);
    timeout_hit = (cnt_q == TIMEOUT_LAST);
    cnt_d       = edge_det ? '0 : captured;
  end

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      level_q <= 1'b0;
      tick_q  <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= CLKIN;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      level_q <= sync2_q;
      tick_q  <= edge_det;
      rise_q  <= rise_det;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      half_q      <= '0;
      valid_q     <= 1'b0;
      range_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (edge_det) state_q <= ARMED;
        end
        ARMED, RUN: begin
          // An edge on the timeout cycle is a legal capture, so it takes priority.
          if (edge_det) begin
            half_q      <= captured;
            range_err_q <= range_bad;
            valid_q     <= 1'b1;
            state_q     <= RUN;
          end else if (timeout_hit) begin
            timeout_q   <= 1'b1;
            valid_q     <= 1'b0;
            range_err_q <= 1'b0;
            state_q     <= LOST;
          end
        end
        LOST: begin
          // The interval spanning the loss is meaningless, so re-arm without capturing.
          if (edge_det) begin
            timeout_q <= 1'b0;
            state_q   <= ARMED;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign LEVEL       = level_q;
  assign TICK        = tick_q;
  assign RISE        = rise_q;
  assign HALF_PERIOD = half_q;
  assign VALID       = valid_q;
  assign RANGE_ERR   = range_err_q;
  assign TIMEOUT     = timeout_q;

endmodule

// File: tb/tb_clkdiv_tick_monitor.sv
// Directed bench for clkdiv_tick_monitor with EXP_HALF=10, TOL=1, TIMEOUT_CYC=30.
// CLKIN is toggled on a cycle schedule; strobes and captures appear three cycles later.
module tb_clkdiv_tick_monitor;

  localparam int CW = 25;

  logic          CLK = 1'b0;
  logic          RST;
  logic          CLKIN;
  logic          LEVEL, TICK, RISE, VALID, RANGE_ERR, TIMEOUT;
  logic [CW-1:0] HALF_PERIOD;

  clkdiv_tick_monitor #(
    .CW          (CW),
    .EXP_HALF    (25'd10),
    .TOL         (25'd1),
    .TIMEOUT_CYC (25'd30)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .CLKIN       (CLKIN),
    .LEVEL       (LEVEL),
    .TICK        (TICK),
    .RISE        (RISE),
    .HALF_PERIOD (HALF_PERIOD),
    .VALID       (VALID),
    .RANGE_ERR   (RANGE_ERR),
    .TIMEOUT     (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int            gap;        // cycles since the previous CLKIN toggle
    logic          exp_level;
    logic          exp_rise;
    logic [CW-1:0] exp_half;
    logic          exp_valid;
    logic          exp_rerr;
    logic          exp_to;
  } vec_t;

  vec_t vecs[15];
  int   pass_cnt    = 0;
  int   total_cnt   = 0;
  int   last_toggle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"},   LEVEL,       0);
    check({tag, "_tick"},    TICK,        0);
    check({tag, "_rise"},    RISE,        0);
    check({tag, "_half"},    HALF_PERIOD, 0);
    check({tag, "_valid"},   VALID,       0);
    check({tag, "_rerr"},    RANGE_ERR,   0);
    check({tag, "_timeout"}, TIMEOUT,     0);
  endtask

  task automatic apply(input int idx);
    vec_t v;
    v = vecs[idx];
    while (cyc < last_toggle + v.gap) step(1);
    CLKIN = ~CLKIN;
    last_toggle = cyc;
    step(2);
    check($sformatf("v%0d_tick_early", idx), TICK, 0);
    step(1);
    check($sformatf("v%0d_tick", idx),    TICK,        1);
    check($sformatf("v%0d_rise", idx),    RISE,        v.exp_rise);
    check($sformatf("v%0d_level", idx),   LEVEL,       v.exp_level);
    check($sformatf("v%0d_half", idx),    HALF_PERIOD, v.exp_half);
    check($sformatf("v%0d_valid", idx),   VALID,       v.exp_valid);
    check($sformatf("v%0d_rerr", idx),    RANGE_ERR,   v.exp_rerr);
    check($sformatf("v%0d_timeout", idx), TIMEOUT,     v.exp_to);
    step(1);
    check($sformatf("v%0d_tick_late", idx), TICK, 0);
    check($sformatf("v%0d_rise_late", idx), RISE, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit tick_seen;

    //          gap lvl   rise  half    valid rerr  to
    vecs[0]  = '{ 5, 1'b1, 1'b1, 25'd0,  1'b0, 1'b0, 1'b0}; // first edge only arms
    vecs[1]  = '{10, 1'b0, 1'b0, 25'd10, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{10, 1'b1, 1'b1, 25'd10, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{11, 1'b0, 1'b0, 25'd11, 1'b1, 1'b0, 1'b0}; // upper bound inclusive
    vecs[4]  = '{12, 1'b1, 1'b1, 25'd12, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{ 9, 1'b0, 1'b0, 25'd9,  1'b1, 1'b0, 1'b0}; // lower bound inclusive
    vecs[6]  = '{ 8, 1'b1, 1'b1, 25'd8,  1'b1, 1'b1, 1'b0};
    vecs[7]  = '{10, 1'b0, 1'b0, 25'd10, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{30, 1'b1, 1'b1, 25'd30, 1'b1, 1'b1, 1'b0}; // edge on the timeout cycle
    vecs[9]  = '{40, 1'b0, 1'b0, 25'd30, 1'b0, 1'b0, 1'b0}; // edge leaving LOST
    vecs[10] = '{10, 1'b1, 1'b1, 25'd10, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{10, 1'b0, 1'b0, 25'd10, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{ 6, 1'b1, 1'b1, 25'd0,  1'b0, 1'b0, 1'b0}; // after async reset
    vecs[13] = '{12, 1'b0, 1'b0, 25'd12, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{10, 1'b1, 1'b1, 25'd10, 1'b1, 1'b0, 1'b0};

    RST   = 1'b1;
    CLKIN = 1'b0;
    step(3);
    check_reset_outputs("reset");
    @(negedge CLK);
    RST = 1'b0;
    step(1);

    // Static input for 100 cycles: IDLE must neither tick nor time out.
    tick_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (TICK) tick_seen = 1'b1;
    end
    check("idle_no_tick", tick_seen, 0);
    check("idle_timeout", TIMEOUT,   0);
    check("idle_valid",   VALID,     0);
    last_toggle = cyc;

    for (int i = 0; i <= 8; i++) apply(i);

    // Input held high: TIMEOUT rises exactly 30 cycles after the last TICK.
    step(28);
    check("lost_not_yet", TIMEOUT, 0);
    step(1);
    check("lost_timeout", TIMEOUT,     1);
    check("lost_valid",   VALID,       0);
    check("lost_rerr",    RANGE_ERR,   0);
    check("lost_half",    HALF_PERIOD, 30);

    for (int i = 9; i <= 11; i++) apply(i);

    // Asynchronous reset in the middle of a RUN interval.
    step(1);
    check("pre_reset_valid", VALID, 1);
    #2;
    RST = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge CLK);
    RST = 1'b0;
    step(1);
    last_toggle = cyc;

    for (int i = 12; i <= 14; i++) apply(i);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
